// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Controller <-> datapath/memory signal bundle for multicycle_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_write;
  logic        dmem_req;
  logic        dmem_we;
  logic        alu_en;
  logic        reg_write;
  logic        pc_write;
  logic        pc_sel;
  logic        illegal;
  logic        bus_err;
  logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    output instret,
`endif
    output imem_req, ir_write, dmem_req, dmem_we, alu_en, reg_write,
    output pc_write, pc_sel, illegal, bus_err, state
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    input  instret,
`endif
    input  imem_req, ir_write, dmem_req, dmem_we, alu_en, reg_write,
    input  pc_write, pc_sel, illegal, bus_err, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : FETCH/DECODE/EXEC/MEM/WB sequencer for a non-pipelined RV32I core,
//          with memory-handshake watchdog. Optional retired-instruction
//          counter enabled by MULTICYCLE_CTRL_INSTRET_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter logic [6:0]  INST_R     = 7'b0110011,
  parameter logic [6:0]  INST_I_LD  = 7'b0000011,
  parameter logic [6:0]  INST_I_IMM = 7'b0010011,
  parameter logic [6:0]  INST_S     = 7'b0100011,
  parameter logic [6:0]  INST_B     = 7'b1100011,
  parameter logic [6:0]  INST_J     = 7'b1101111,
  parameter logic [6:0]  INST_U     = 7'b0110111,
  parameter int unsigned TIMEOUT    = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_HALT   = 3'd5;

  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_nextState;
  logic [7:0] r_waitCnt;
  logic       r_illegal;
  logic       r_busErr;
  logic       w_setIllegal;
  logic       w_setBusErr;
  logic       w_pcWrite;

  logic w_isLoad, w_isStore, w_isBranch, w_isWbClass, w_legal;

  assign w_isLoad    = (bus.opcode == INST_I_LD);
  assign w_isStore   = (bus.opcode == INST_S);
  assign w_isBranch  = (bus.opcode == INST_B);
  assign w_isWbClass = (bus.opcode == INST_R) || (bus.opcode == INST_I_IMM) ||
                       (bus.opcode == INST_U) || (bus.opcode == INST_J);
  assign w_legal     = w_isLoad || w_isStore || w_isBranch || w_isWbClass;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; ready beats the watchdog when both land in the same cycle
  always_comb begin
    w_nextState  = r_state;
    w_setIllegal = 1'b0;
    w_setBusErr  = 1'b0;
    case (r_state)
      c_FETCH: begin
        if (bus.imem_ready) begin
          w_nextState = c_DECODE;
        end else if (r_waitCnt >= c_WAIT_LAST) begin
          w_nextState = c_HALT;
          w_setBusErr = 1'b1;
        end
      end
      c_DECODE: begin
        if (w_legal) begin
          w_nextState = c_EXEC;
        end else begin
          w_nextState  = c_HALT;
          w_setIllegal = 1'b1;
        end
      end
      c_EXEC: begin
        if (w_isLoad || w_isStore) begin
          w_nextState = c_MEM;
        end else if (w_isWbClass) begin
          w_nextState = c_WB;
        end else begin
          w_nextState = c_FETCH;
        end
      end
      c_MEM: begin
        if (bus.dmem_ready) begin
          w_nextState = w_isStore ? c_FETCH : c_WB;
        end else if (r_waitCnt >= c_WAIT_LAST) begin
          w_nextState = c_HALT;
          w_setBusErr = 1'b1;
        end
      end
      c_WB:    w_nextState = c_FETCH;
      c_HALT:  w_nextState = c_HALT;
      default: w_nextState = c_FETCH;
    endcase
  end

  // Outputs; everything is forced low while reset is held
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.alu_en    = 1'b0;
    bus.reg_write = 1'b0;
    w_pcWrite     = 1'b0;
    bus.pc_sel    = 1'b0;
    if (!rst) begin
      case (r_state)
        c_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_write = bus.imem_ready;
        end
        c_EXEC: begin
          bus.alu_en = 1'b1;
          if (w_isBranch) begin
            w_pcWrite  = 1'b1;
            bus.pc_sel = bus.branch_taken;
          end
        end
        c_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = w_isStore;
          w_pcWrite    = w_isStore && bus.dmem_ready;
        end
        c_WB: begin
          bus.reg_write = 1'b1;
          w_pcWrite     = 1'b1;
          bus.pc_sel    = (bus.opcode == INST_J);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write = w_pcWrite;
  assign bus.state    = rst ? 3'd0 : r_state;
  assign bus.illegal  = r_illegal & ~rst;
  assign bus.bus_err  = r_busErr & ~rst;

  // Wait counter: only runs while a handshake is pending, saturating
  always_ff @(posedge clk) begin
    if (rst || (w_nextState != r_state)) begin
      r_waitCnt <= 8'd0;
    end else if (((r_state == c_FETCH) && !bus.imem_ready) ||
                 ((r_state == c_MEM) && !bus.dmem_ready)) begin
      if (r_waitCnt != 8'hFF) begin
        r_waitCnt <= r_waitCnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      if (w_setIllegal) r_illegal <= 1'b1;
      if (w_setBusErr)  r_busErr  <= 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= 32'd0;
    end else if (w_pcWrite && (r_state != c_HALT)) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign bus.instret = rst ? 32'd0 : r_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Randomised scoreboard bench for multicycle_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int TO = 16;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_U  = 7'b0110111;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_H = 3'd5;

  // One clock cycle of stimulus plus the outputs it must produce
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        bt;
    logic        ir;
    logic        dr;
    logic [12:0] exp;
    logic [31:0] ret;
  } rec_t;

  rec_t stimQ[$];
  rec_t sbQ[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit          mIll;
  bit          mBus;
  logic [31:0] mRet;

  logic [6:0] legalOps [7];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic bit isLegal(input logic [6:0] op);
    return op inside {OP_R, OP_LD, OP_I, OP_S, OP_B, OP_J, OP_U};
  endfunction

  // en = {imem_req, ir_write, dmem_req, dmem_we, alu_en, reg_write, pc_write, pc_sel}
  task automatic emit(input logic r, input logic [6:0] op, input logic bt,
                      input logic ir, input logic dr, input logic [2:0] st,
                      input logic [7:0] en);
    rec_t x;
    x.rst = r; x.op = op; x.bt = bt; x.ir = ir; x.dr = dr;
    if (r) begin
      x.exp = '0; x.ret = '0;
      mIll = 0; mBus = 0; mRet = '0;
    end else begin
      x.exp = {st, en, mIll, mBus};
      x.ret = mRet;
      if (en[1]) mRet = mRet + 32'd1;
    end
    stimQ.push_back(x);
  endtask

  task automatic doReset();
    emit(1'b1, junk(), rb(), rb(), rb(), ST_F, 8'h00);
  endtask

  task automatic haltAndReset(input int n);
    repeat (n) emit(1'b0, junk(), rb(), rb(), rb(), ST_H, 8'h00);
    doReset();
  endtask

  task automatic doWb(input logic [6:0] op);
    emit(1'b0, op, rb(), rb(), rb(), ST_W, {6'b000001, 1'b1, op == OP_J});
  endtask

  task automatic doFetch(input int w, output bit ok);
    ok = 0;
    for (int k = 0; k < TO; k++) begin
      if (k >= w) begin
        emit(1'b0, junk(), rb(), 1'b1, rb(), ST_F, 8'b1100_0000);
        ok = 1;
        return;
      end
      emit(1'b0, junk(), rb(), 1'b0, rb(), ST_F, 8'b1000_0000);
    end
    mBus = 1;
  endtask

  task automatic doMem(input logic [6:0] op, input int w, input int abortAt);
    bit st;
    st = (op == OP_S);
    for (int k = 0; k < TO; k++) begin
      if (k == abortAt) begin
        doReset();
        return;
      end
      if (k >= w) begin
        emit(1'b0, op, rb(), rb(), 1'b1, ST_M, {4'b0010 | {3'b000, st}, 2'b00, st, 1'b0});
        if (!st) doWb(op);
        return;
      end
      emit(1'b0, op, rb(), rb(), 1'b0, ST_M, {2'b00, 1'b1, st, 4'b0000});
    end
    mBus = 1;
    haltAndReset(3);
  endtask

  task automatic doInstr(input logic [6:0] op, input logic bt, input int fw,
                         input int mw, input int abortAt);
    bit ok;
    doFetch(fw, ok);
    if (!ok) begin
      haltAndReset(2 + $urandom_range(0, 4));
      return;
    end
    emit(1'b0, op, rb(), rb(), rb(), ST_D, 8'h00);
    if (!isLegal(op)) begin
      mIll = 1;
      haltAndReset(3);
      return;
    end
    if (op == OP_B) begin
      emit(1'b0, op, bt, rb(), rb(), ST_E, {4'b0000, 1'b1, 1'b0, 1'b1, bt});
      return;
    end
    emit(1'b0, op, bt, rb(), rb(), ST_E, 8'b0000_1000);
    if (op == OP_LD || op == OP_S) doMem(op, mw, abortAt);
    else doWb(op);
  endtask

  function automatic int pickWait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return TO;
    if (r == 1) return TO - 1;
    return int'($urandom_range(0, 3));
  endfunction

  // Driver: applies one record per cycle just after the rising edge
  initial begin
    rec_t x;
    bus.opcode = '0; bus.branch_taken = 0; bus.imem_ready = 0; bus.dmem_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stimQ.size() > 0) begin
        x = stimQ.pop_front();
        rst              = x.rst;
        bus.opcode       = x.op;
        bus.branch_taken = x.bt;
        bus.imem_ready   = x.ir;
        bus.dmem_ready   = x.dr;
        sbQ.push_back(x);
      end
    end
  end

  // Monitor: compares the outputs of each issued cycle on the falling edge
  initial begin
    rec_t e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        act = {bus.state, bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we,
               bus.alu_en, bus.reg_write, bus.pc_write, bus.pc_sel,
               bus.illegal, bus.bus_err};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL outputs cyc=%0d got=%b want=%b (state,en8,illegal,bus_err)",
                   cyc, act, e.exp);
        end
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        checks++;
        if (bus.instret !== e.ret) begin
          errors++;
          $display("FAIL instret cyc=%0d got=%0d want=%0d", cyc, bus.instret, e.ret);
        end
`endif
        cyc++;
      end
    end
  end

  initial begin
    logic [6:0] op;
    int r, fw, mw, ab;
    legalOps = '{OP_R, OP_LD, OP_I, OP_S, OP_B, OP_J, OP_U};
    mIll = 0; mBus = 0; mRet = '0;

    doReset();
    doInstr(OP_R, 1'b0, 0, 0, -1);
    doInstr(OP_LD, 1'b0, 0, 3, -1);
    doInstr(OP_B, 1'b1, 0, 0, -1);
    doInstr(OP_B, 1'b0, 1, 0, -1);
    doInstr(OP_J, 1'b0, 0, 0, -1);
    doFetch(0, r[0]);
    emit(1'b0, 7'h7F, rb(), rb(), rb(), ST_D, 8'h00);
    mIll = 1;
    haltAndReset(20);
    doInstr(OP_R, 1'b0, TO, 0, -1);
    doInstr(OP_R, 1'b0, TO - 1, 0, -1);
    doInstr(OP_LD, 1'b0, 0, TO, -1);
    doInstr(OP_S, 1'b0, 0, TO - 1, -1);
    doInstr(OP_R, 1'b0, 0, 0, -1);
    doInstr(OP_S, 1'b0, 0, 0, -1);
    doInstr(OP_B, 1'b1, 0, 0, -1);
    doInstr(OP_S, 1'b0, 0, 5, 2);
    doInstr(OP_I, 1'b0, 0, 0, -1);
    doInstr(OP_U, 1'b0, 2, 0, -1);

    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r == 0) ? junk() : legalOps[$urandom_range(0, 6)];
      fw = pickWait();
      mw = pickWait();
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      doInstr(op, rb(), fw, mw, ab);
    end

    for (int i = 0; i < 50000 && (stimQ.size() > 0 || sbQ.size() > 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    if (stimQ.size() > 0 || sbQ.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", stimQ.size() + sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
